tanh_input_requant: RTL and testbench

TANH_INPUT_REQUANT -- requirements
Module: tanh_input_requant

---
 rtl/tanh_input_requant_if.sv | 27 ++
 rtl/tanh_input_requant.sv | 111 +++++++++++
 tb/tb_tanh_input_requant.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tanh_input_requant_if.sv
// Stream interface for the tanh input requantiser: accumulator samples in,
// Q3.5 results out, each with a valid/ready handshake.
interface tanh_input_requant_if #(
  parameter int ACC_W = 24
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [ACC_W-1:0] in_acc;
  logic        [7:0]       in_scale;
  logic        [4:0]       in_shift;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [7:0]       out_x;
  logic                    out_sat;

  // Producer/consumer side: drives samples in and accepts results.
  modport master (
    output in_valid, in_acc, in_scale, in_shift, out_ready,
    input  in_ready, out_valid, out_x, out_sat
  );

  // Requantiser side.
  modport slave (
    input  in_valid, in_acc, in_scale, in_shift, out_ready,
    output in_ready, out_valid, out_x, out_sat
  );
endinterface

// File: rtl/tanh_input_requant.sv
// Requantises a signed accumulator into the Q3.5 input of a tanh stage:
// exact multiply by an unsigned scale, round-half-up right shift, clamp to
// 8 bits. Two-stage elastic pipeline with a saturation-event counter.
module tanh_input_requant #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  tanh_input_requant_if.slave  bus,
  input  logic                 clr_count,
  output logic [CNT_W-1:0]     sat_count
);

  localparam int PW = ACC_W + 9;
  // Wide enough for the product plus the largest rounding increment (2^30).
  localparam int RW = (PW + 1 > 33) ? PW + 1 : 33;
  localparam logic signed [RW-1:0] SAT_HI = RW'(127);
  localparam logic signed [RW-1:0] SAT_LO = RW'(-128);

  logic                 in_fire;
  logic                 out_fire;
  logic                 s2_load;
  logic signed [PW-1:0] prod;

  logic                 s1_v;
  logic signed [PW-1:0] s1_prod;
  logic        [4:0]    s1_shift;

  logic                 s2_v;
  logic        [7:0]    s2_x;
  logic                 s2_sat;

  logic signed [RW-1:0] rnd_inc;
  logic signed [RW-1:0] rnd_sum;
  logic signed [RW-1:0] shifted;
  logic        [7:0]    res_x;
  logic                 res_sat;

  // Handshake: S2 refills when empty or draining; S1 accepts when empty or
  // emptying into S2. in_ready is forced low while reset is asserted.
  assign out_fire     = s2_v & bus.out_ready;
  assign s2_load      = s1_v & (~s2_v | out_fire);
  assign bus.in_ready = reset & (~s1_v | s2_load);
  assign in_fire      = bus.in_valid & bus.in_ready;

  assign prod = PW'(bus.in_acc) * PW'($signed({1'b0, bus.in_scale}));

  assign bus.out_valid = s2_v;
  assign bus.out_x     = s2_x;
  assign bus.out_sat   = s2_sat;

  // Round half toward +inf, arithmetic shift, then clamp to the Q3.5 range.
  always_comb begin
    rnd_inc = '0;
    if (s1_shift != 5'd0)
      rnd_inc = RW'(1) << (s1_shift - 5'd1);
    rnd_sum = RW'(s1_prod) + rnd_inc;
    shifted = rnd_sum >>> s1_shift;
    res_x   = shifted[7:0];
    res_sat = 1'b0;
    if (shifted > SAT_HI) begin
      res_x   = 8'h7f;
      res_sat = 1'b1;
    end else if (shifted < SAT_LO) begin
      res_x   = 8'h80;
      res_sat = 1'b1;
    end
  end

  // Stage 1: exact product and its shift amount.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v     <= 1'b0;
      s1_prod  <= '0;
      s1_shift <= '0;
    end else if (in_fire) begin
      s1_v     <= 1'b1;
      s1_prod  <= prod;
      s1_shift <= bus.in_shift;
    end else if (s2_load) begin
      s1_v     <= 1'b0;
    end
  end

  // Stage 2: rounded and saturated result presented downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_v   <= 1'b0;
      s2_x   <= '0;
      s2_sat <= 1'b0;
    end else if (s2_load) begin
      s2_v   <= 1'b1;
      s2_x   <= res_x;
      s2_sat <= res_sat;
    end else if (out_fire) begin
      s2_v   <= 1'b0;
    end
  end

  // Saturation counter: clear wins over increment; sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sat_count <= '0;
    else if (clr_count)
      sat_count <= '0;
    else if (out_fire && s2_sat && (sat_count != '1))
      sat_count <= sat_count + 1'b1;
  end

endmodule

// File: tb/tb_tanh_input_requant.sv
// Self-checking bench for tanh_input_requant (built with CNT_W=4 so the
// counter ceiling is reachable quickly).
module tb_tanh_input_requant;

  logic       clk;
  logic       reset;
  logic       clr_count;
  logic [3:0] sat_count;

  tanh_input_requant_if #(.ACC_W(24)) bus ();

  tanh_input_requant #(.ACC_W(24), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clr_count (clr_count),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       smp_irdy;
  logic       smp_ovld;
  logic [7:0] smp_x;
  logic       smp_sat;
  logic [3:0] smp_cnt;

  logic [8:0] exp_q[$];

  // Reference: plain integer arithmetic on the requantisation rules.
  function automatic void ref_model(input logic signed [23:0] acc, input logic [7:0] sc,
                                    input logic [4:0] sh, output logic [7:0] x, output logic s);
    longint a, m, p, r;
    a = acc;
    m = {56'd0, sc};
    p = a * m;
    if (sh != 0) p = p + (longint'(1) << (sh - 1));
    r = p >>> sh;
    s = 1'b0;
    if (r > 127) begin x = 8'h7f; s = 1'b1; end
    else if (r < -128) begin x = 8'h80; s = 1'b1; end
    else x = r[7:0];
  endfunction

  // Called at posedge+1: sample mid-cycle, then advance to next posedge+1.
  task automatic tick();
    #4;
    smp_irdy = bus.in_ready;
    smp_ovld = bus.out_valid;
    smp_x    = bus.out_x;
    smp_sat  = bus.out_sat;
    smp_cnt  = sat_count;
    @(posedge clk);
    #1;
  endtask

  // Presents one sample with out_ready=1; lat counts cycles from the
  // accepting cycle to the cycle out_valid is seen (-1 on timeout).
  task automatic send_one(input logic signed [23:0] acc, input logic [7:0] sc, input logic [4:0] sh,
                          output logic [7:0] x, output logic s, output int lat);
    logic ok;
    lat = -1; x = '0; s = 1'b0; ok = 1'b0;
    bus.in_acc = acc; bus.in_scale = sc; bus.in_shift = sh;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      ok = smp_irdy;
    end
    bus.in_valid = 1'b0;
    if (ok) begin
      for (int i = 1; i <= 10; i++) begin
        tick();
        if (smp_ovld) begin
          lat = i; x = smp_x; s = smp_sat;
          break;
        end
      end
    end
  endtask

  task automatic pulse_clr();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_x !== 8'sd0 ||
        bus.out_sat !== 1'b0 || sat_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_x=%0d out_sat=%b sat_count=%0d required 0/0/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_x, bus.out_sat, sat_count);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    n_tests++;
    if (smp_irdy !== 1'b1 || smp_ovld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", smp_irdy, smp_ovld);
    end
  endtask

  task automatic test_basic();
    logic signed [23:0] va[4] = '{24'sd1000, -24'sd1000, 24'sd0, 24'sd0};
    logic [7:0]         vs[4] = '{8'd16, 8'd16, 8'd200, 8'd0};
    logic [4:0]         vh[4] = '{5'd7, 5'd7, 5'd13, 5'd0};
    logic signed [7:0]  ex[4] = '{8'sd125, -8'sd125, 8'sd0, 8'sd0};
    logic [7:0] x; logic s; int lat;
    for (int i = 0; i < 4; i++) begin
      send_one(va[i], vs[i], vh[i], x, s, lat);
      n_tests++;
      if (x !== ex[i]) begin
        n_fail++;
        $display("FAIL basic_x[%0d]: got %0d required %0d", i, $signed(x), ex[i]);
      end
      n_tests++;
      if (s !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_sat[%0d]: got %b required 0", i, s);
      end
      n_tests++;
      if (lat != 2) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: got %0d required 2", i, lat);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] x; logic s; int lat;
    send_one(24'sd100000, 8'd255, 5'd0, x, s, lat);
    n_tests++;
    if (x !== 8'h7f || s !== 1'b1 || sat_count !== 4'd1) begin
      n_fail++;
      $display("FAIL sat_pos: x=%0d sat=%b cnt=%0d required 127/1/1", $signed(x), s, sat_count);
    end
    send_one(-24'sd100000, 8'd255, 5'd0, x, s, lat);
    n_tests++;
    if (x !== 8'h80 || s !== 1'b1 || sat_count !== 4'd2) begin
      n_fail++;
      $display("FAIL sat_neg: x=%0d sat=%b cnt=%0d required -128/1/2", $signed(x), s, sat_count);
    end
    pulse_clr();
    n_tests++;
    if (sat_count !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_clear: cnt=%0d required 0", sat_count);
    end
    // Park a saturating result in the output stage, then release it on the
    // same edge as a clear.
    bus.out_ready = 1'b0;
    bus.in_acc = 24'sd100000; bus.in_scale = 8'd255; bus.in_shift = 5'd0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    bus.out_ready = 1'b1;
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    n_tests++;
    if (smp_ovld !== 1'b1 || sat_count !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_priority: out_valid=%b cnt=%0d required 1/0", smp_ovld, sat_count);
    end
    tick();
    n_tests++;
    if (smp_ovld !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_no_dup: out_valid=%b required 0", smp_ovld);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [23:0] a[8];
    logic [7:0] sc[8];
    logic [4:0] sh[8];
    logic [7:0] ex; logic es; logic [8:0] e;
    int idx = 0, got = 0;
    logic saw_drop = 1'b0, prev_stall = 1'b0;
    logic [8:0] prev_out = '0;
    for (int i = 0; i < 8; i++) begin
      a[i] = 24'($urandom); sc[i] = 8'($urandom); sh[i] = 5'($urandom_range(8, 31));
    end
    exp_q.delete();
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      bus.in_valid = (idx < 8);
      if (idx < 8) begin
        bus.in_acc = a[idx]; bus.in_scale = sc[idx]; bus.in_shift = sh[idx];
      end
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      tick();
      if (bus.out_ready && bus.in_valid) begin
        n_tests++;
        if (smp_irdy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_bubble: cycle %0d in_ready=%b required 1", cyc, smp_irdy);
        end
      end
      if (!bus.out_ready && !smp_irdy) saw_drop = 1'b1;
      if (prev_stall) begin
        n_tests++;
        if (smp_ovld !== 1'b1 || {smp_sat, smp_x} !== prev_out) begin
          n_fail++;
          $display("FAIL b2b_hold: cycle %0d valid=%b out=%h required 1/%h", cyc, smp_ovld, {smp_sat, smp_x}, prev_out);
        end
      end
      if (bus.in_valid && smp_irdy) begin
        ref_model(a[idx], sc[idx], sh[idx], ex, es);
        exp_q.push_back({es, ex});
        idx++;
      end
      if (smp_ovld && bus.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
        n_tests++;
        if ({smp_sat, smp_x} !== e) begin
          n_fail++;
          $display("FAIL b2b_data[%0d]: got %h required %h", got, {smp_sat, smp_x}, e);
        end
        got++;
      end
      prev_stall = smp_ovld && !bus.out_ready;
      prev_out   = {smp_sat, smp_x};
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n_tests++;
    if (got != 8 || !saw_drop) begin
      n_fail++;
      $display("FAIL b2b_complete: delivered=%0d in_ready_dropped=%b required 8/1", got, saw_drop);
    end
  endtask

  task automatic test_random_stream();
    localparam int N = 150;
    int sent = 0, got = 0, nsat = 0;
    logic pend = 1'b0, prev_stall = 1'b0;
    logic [8:0] prev_out = '0, e;
    logic [7:0] ex; logic es;
    pulse_clr();
    exp_q.delete();
    for (int cyc = 0; cyc < 2000 && (got < N); cyc++) begin
      if (!pend && sent < N && $urandom_range(0, 9) < 7) begin
        pend = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          bus.in_acc = 24'($urandom);
          bus.in_shift = 5'($urandom);
        end else begin
          bus.in_acc = 24'(int'($urandom_range(0, 4000)) - 2000);
          bus.in_shift = 5'($urandom_range(0, 10));
        end
        bus.in_scale = 8'($urandom);
      end
      bus.in_valid  = pend;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      tick();
      if (bus.out_ready && bus.in_valid) begin
        n_tests++;
        if (smp_irdy !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_ready: cycle %0d in_ready=%b required 1", cyc, smp_irdy);
        end
      end
      if (prev_stall) begin
        n_tests++;
        if (smp_ovld !== 1'b1 || {smp_sat, smp_x} !== prev_out) begin
          n_fail++;
          $display("FAIL rand_hold: cycle %0d valid=%b out=%h required 1/%h", cyc, smp_ovld, {smp_sat, smp_x}, prev_out);
        end
      end
      if (pend && smp_irdy) begin
        ref_model(bus.in_acc, bus.in_scale, bus.in_shift, ex, es);
        exp_q.push_back({es, ex});
        sent++;
        pend = 1'b0;
      end
      if (smp_ovld && bus.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
        n_tests++;
        if ({smp_sat, smp_x} !== e) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: got %h required %h", got, {smp_sat, smp_x}, e);
        end
        if (e[8]) nsat++;
        got++;
      end
      prev_stall = smp_ovld && !bus.out_ready;
      prev_out   = {smp_sat, smp_x};
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n_tests++;
    if (got != N) begin
      n_fail++;
      $display("FAIL rand_complete: delivered=%0d required %0d", got, N);
    end
    n_tests++;
    if (sat_count !== 4'((nsat > 15) ? 15 : nsat)) begin
      n_fail++;
      $display("FAIL rand_count: got %0d required %0d", sat_count, (nsat > 15) ? 15 : nsat);
    end
  endtask

  task automatic test_reset_midflight();
    logic [7:0] x; logic s; int lat;
    logic stale = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_acc = 24'sd5000; bus.in_scale = 8'd3; bus.in_shift = 5'd4;
    tick();
    bus.in_acc = -24'sd700;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_setup: out_valid=%b required 1", bus.out_valid);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_async: out_valid=%b in_ready=%b required 0/0", bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (smp_ovld) stale = 1'b1;
    end
    n_tests++;
    if (stale) begin
      n_fail++;
      $display("FAIL midflight_stale: out_valid seen=1 required 0");
    end
    send_one(24'sd1000, 8'd16, 5'd7, x, s, lat);
    n_tests++;
    if (x !== 8'd125 || lat != 2) begin
      n_fail++;
      $display("FAIL midflight_after: x=%0d lat=%0d required 125/2", $signed(x), lat);
    end
  endtask

  task automatic test_sat_hold();
    int acc_n = 0, del = 0;
    pulse_clr();
    bus.out_ready = 1'b1;
    bus.in_acc = 24'sd100000; bus.in_scale = 8'd255; bus.in_shift = 5'd0;
    for (int i = 0; i < 60 && (acc_n < 20 || del < 20); i++) begin
      bus.in_valid = (acc_n < 20);
      tick();
      if (bus.in_valid && smp_irdy) acc_n++;
      if (smp_ovld) del++;
    end
    bus.in_valid = 1'b0;
    n_tests++;
    if (del != 20 || sat_count !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_hold: delivered=%0d cnt=%0d required 20/15", del, sat_count);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_acc = '0; bus.in_scale = '0; bus.in_shift = '0;
    bus.out_ready = 1'b1; clr_count = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_random_stream();
    test_reset_midflight();
    test_sat_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
